// File: rtl/digit_scan_ctrl.sv
// Scan controller driving a 2-to-4 decoder select: BLANK/SHOW per slot, four slots per frame.
// Frame data is double-buffered through a valid/ready port and committed at frame boundaries.
module digit_scan_ctrl #(
  parameter int DW        = 4,
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 8,
  parameter int CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [3:0]      digit_mask,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [4*DW-1:0] load_data,
  output logic [1:0]      sel,
  output logic            sel_valid,
  output logic [DW-1:0]   digit_data,
  output logic            frame_done
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(TICK_DIV - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       sel_n;
  logic             frame_edge;

  logic [4*DW-1:0]  active, active_n, pending;
  logic             pend_flag;
  logic [3:0]       mask_q;
  logic             accept, commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sel   <= sel_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sel_n      = sel;
    frame_edge = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        sel_n = 2'd0;
        if (en) state_n = BLANK;
      end
      BLANK: begin
        if (!en) begin
          state_n = IDLE;
          cnt_n   = '0;
          sel_n   = 2'd0;
        end else if (cnt == BLANK_LAST) begin
          state_n = SHOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHOW: begin
        if (!en) begin
          state_n = IDLE;
          cnt_n   = '0;
          sel_n   = 2'd0;
        end else if (cnt == SHOW_LAST) begin
          state_n    = BLANK;
          cnt_n      = '0;
          sel_n      = sel + 2'd1;
          frame_edge = (sel == 2'd3);
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        sel_n   = 2'd0;
      end
    endcase
  end

  always_comb begin
    sel_valid = (state == SHOW) && mask_q[sel];
  end

  assign load_ready = !pend_flag;
  assign accept     = load_valid && load_ready;
  // While idle there is no frame in flight, so pending data may commit right away.
  assign commit     = pend_flag && (frame_edge || (state == IDLE));
  assign active_n   = commit ? pending : active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= '0;
      pending    <= '0;
      pend_flag  <= 1'b0;
      frame_done <= 1'b0;
      mask_q     <= 4'd0;
      digit_data <= '0;
    end else begin
      active     <= active_n;
      frame_done <= frame_edge;
      mask_q     <= digit_mask;
      // Track the next select so the word is already in place on the first SHOW cycle.
      digit_data <= active_n[sel_n*DW +: DW];
      if (accept) begin
        pending   <= load_data;
        pend_flag <= 1'b1;
      end else if (commit) begin
        pend_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with TICK_DIV=4, BLANK_CYC=2 (slot 6, frame 24 cycles).
module tb_digit_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  digit_mask;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [1:0]  sel;
  logic        sel_valid;
  logic [3:0]  digit_data;
  logic        frame_done;

  int passed = 0;
  int total  = 0;

  logic [15:0] act_m;
  logic [15:0] pend_dat;
  logic        pend_m;

  digit_scan_ctrl #(.DW(4), .TICK_DIV(4), .BLANK_CYC(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digit_mask(digit_mask),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .sel(sel), .sel_valid(sel_valid), .digit_data(digit_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Runs one 24-cycle frame starting at its first BLANK cycle, checking every cycle.
  // A load is offered at cycle load_at (-1 for none).
  task automatic run_frame(input logic fd0, input logic [3:0] mask, input int load_at,
                           input logic [15:0] ld);
    for (int i = 0; i < 24; i++) begin
      int slot;
      int ph;
      logic show;
      logic [15:0] a;
      slot = i / 6;
      ph   = i % 6;
      show = (ph >= 2);
      a    = act_m;
      chk("sel", 32'(sel), 32'(slot));
      chk("sel_valid", 32'(sel_valid), 32'(show && mask[slot]));
      chk("frame_done", 32'(frame_done), 32'((i == 0) && fd0));
      chk("load_ready", 32'(load_ready), 32'(!pend_m));
      if (show) chk("digit_data", 32'(digit_data), 32'(a[slot*4 +: 4]));
      if (i == load_at) begin
        load_valid = 1'b1;
        load_data  = ld;
      end
      if (i == 23 && pend_m) begin
        act_m  = pend_dat;
        pend_m = 1'b0;
      end else if (i == load_at && !pend_m) begin
        pend_dat = ld;
        pend_m   = 1'b1;
      end
      step();
      load_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    digit_mask = 4'hF;
    load_valid = 1'b0;
    load_data  = 16'h0;
    act_m      = 16'h0;
    pend_dat   = 16'h0;
    pend_m     = 1'b0;
    #1;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_sel", 32'(sel), 32'd0);
    chk("idle_sel_valid", 32'(sel_valid), 32'd0);
    chk("idle_frame_done", 32'(frame_done), 32'd0);
    chk("idle_load_ready", 32'(load_ready), 32'd1);

    // Load in IDLE, then enable on the commit edge.
    load_valid = 1'b1;
    load_data  = 16'h4321;
    step();
    load_valid = 1'b0;
    chk("idle_pending_ready", 32'(load_ready), 32'd0);
    pend_dat = 16'h4321;
    en = 1'b1;
    step();
    act_m  = 16'h4321;
    pend_m = 1'b0;
    chk("idle_commit_ready", 32'(load_ready), 32'd1);

    run_frame(1'b0, 4'hF, -1, 16'h0);
    // Load mid slot 1 SHOW; current frame must be unaffected.
    run_frame(1'b1, 4'hF, 9, 16'hABCD);
    chk("committed_abcd", 32'(act_m), 32'h0000ABCD);
    // Load on the frame-boundary edge with pending empty.
    run_frame(1'b1, 4'hF, 23, 16'h1357);
    digit_mask = 4'b1011;
    run_frame(1'b1, 4'b1011, -1, 16'h0);
    digit_mask = 4'hF;
    run_frame(1'b1, 4'hF, -1, 16'h0);

    // Disable during slot 1 SHOW.
    for (int k = 0; k < 9; k++) step();
    chk("pre_dis_sel", 32'(sel), 32'd1);
    chk("pre_dis_valid", 32'(sel_valid), 32'd1);
    chk("pre_dis_data", 32'(digit_data), 32'h5);
    en = 1'b0;
    step();
    chk("dis_sel", 32'(sel), 32'd0);
    chk("dis_valid", 32'(sel_valid), 32'd0);
    chk("dis_frame_done", 32'(frame_done), 32'd0);
    step();
    chk("dis2_valid", 32'(sel_valid), 32'd0);
    chk("dis2_frame_done", 32'(frame_done), 32'd0);
    en = 1'b1;
    step();
    chk("re_b1_sel", 32'(sel), 32'd0);
    chk("re_b1_valid", 32'(sel_valid), 32'd0);
    step();
    chk("re_b2_valid", 32'(sel_valid), 32'd0);
    step();
    chk("re_s_sel", 32'(sel), 32'd0);
    chk("re_s_valid", 32'(sel_valid), 32'd1);
    chk("re_s_data", 32'(digit_data), 32'h7);

    // Leave a load pending, then reset asynchronously between edges.
    load_valid = 1'b1;
    load_data  = 16'hFFFF;
    step();
    load_valid = 1'b0;
    chk("pre_rst_ready", 32'(load_ready), 32'd0);
    chk("pre_rst_valid", 32'(sel_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_valid", 32'(sel_valid), 32'd0);
    chk("arst_data", 32'(digit_data), 32'd0);
    chk("arst_frame_done", 32'(frame_done), 32'd0);
    chk("arst_ready", 32'(load_ready), 32'd1);
    step();
    rst_n = 1'b1;
    en = 1'b0;
    step();
    step();
    chk("post_rst_ready", 32'(load_ready), 32'd1);
    chk("post_rst_valid", 32'(sel_valid), 32'd0);
    chk("post_rst_data", 32'(digit_data), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
